// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency per op; the divider is built only with MULDIV_DIV_EN.
// No backpressure: start is ignored while busy; without MULDIV_DIV_EN divide ops finish after 1 cycle with illegalOp.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic [4:0]      rdIn,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdOut,
    output logic            regWrite,
    output logic            illegalOp
);

`ifdef MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    localparam logic [5:0] LAST_STEP = 6'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     res_q;
    logic [4:0]          rdout_q;
    logic                rw_q;
    logic                illop_q;

    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic [5:0]          cnt_q;
    logic                neg_q;
    logic                ill_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   prod_q;

`ifdef MULDIV_DIV_EN
    logic                a_neg_q;
    logic                b_zero_q;
    logic [XLEN-1:0]     opa_q;
    logic [XLEN-1:0]     dvsr_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
`endif

    logic                a_sgn;
    logic                b_sgn;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     abs_a;
    logic [XLEN-1:0]     abs_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN-1:0]     div_res;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign rdOut     = rdout_q;
    assign regWrite  = rw_q;
    assign illegalOp = illop_q;

    // Both datapaths work on magnitudes; the sign is restored once at the end.
    always_comb begin
        a_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        b_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
        a_neg = a_sgn & operandA[XLEN-1];
        b_neg = b_sgn & operandB[XLEN-1];
        abs_a = a_neg ? -operandA : operandA;
        abs_b = b_neg ? -operandB : operandB;
    end

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {mul_sum, prod_q[XLEN-1:1]};
        prod_fix  = neg_q ? -prod_q : prod_q;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    // Restoring step: the partial remainder never exceeds the divisor, so XLEN+1 bits suffice.
    always_comb begin
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, dvsr_q};
        quo_fix   = neg_q ? -quo_q : quo_q;
        rem_fix   = a_neg_q ? -rem_q : rem_q;
        if (b_zero_q) begin
            div_res = op_q[1] ? opa_q : '1;
        end else begin
            div_res = op_q[1] ? rem_fix : quo_fix;
        end
    end
`else
    always_comb begin
        div_res = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            rdout_q  <= '0;
            rw_q     <= 1'b0;
            illop_q  <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
`ifdef MULDIV_DIV_EN
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            opa_q    <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            illop_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        op_q     <= funct3;
                        rd_q     <= rdIn;
                        cnt_q    <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        ill_q    <= funct3[2] & ~DIV_EN;
                        mcand_q  <= abs_a;
                        prod_q   <= {{XLEN{1'b0}}, abs_b};
`ifdef MULDIV_DIV_EN
                        a_neg_q  <= a_neg;
                        b_zero_q <= (operandB == '0);
                        opa_q    <= operandA;
                        dvsr_q   <= abs_b;
                        rem_q    <= '0;
                        quo_q    <= abs_a;
`endif
                    end
                end
                S_CALC: begin
                    if (ill_q || cnt_q == LAST_STEP) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rdout_q <= rd_q;
                        illop_q <= ill_q;
                        rw_q    <= ~ill_q & (rd_q != 5'd0);
                        res_q   <= ill_q ? '0 : (op_q[2] ? div_res : mul_res);
                    end else begin
                        cnt_q  <= cnt_q + 6'd1;
                        prod_q <= prod_step;
`ifdef MULDIV_DIV_EN
                        if (!div_diff[XLEN]) begin
                            rem_q <= div_diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  rdIn;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;
    logic        regWrite;
    logic        illegalOp;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .rdIn     (rdIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rdOut    (rdOut),
        .regWrite (regWrite),
        .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : ia / ib;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : ia % ib;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Presents a request for exactly one edge, then scrambles the inputs.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        funct3   = f;
        operandA = a;
        operandB = b;
        rdIn     = rd;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = 3'($urandom);
        operandA = $urandom;
        operandB = $urandom;
        rdIn     = 5'($urandom);
    endtask

    // Waits for done after an accepted request; optionally pokes start mid-operation.
    task automatic finish_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input int poke);
        bit          ill;
        int          lat;
        int          cyc;
        bit          seen;
        bit          busy_lost;
        logic [31:0] exp_res;
        ill       = f[2] && !DIV_EN;
        lat       = ill ? 1 : 33;
        exp_res   = ill ? 32'd0 : ref_res(f, a, b);
        cyc       = 0;
        seen      = 1'b0;
        busy_lost = 1'b0;
        if (!ill) check_eq({tag, ":busy_after_accept"}, 64'(busy), 64'd1);
        while (!seen && cyc < 40) begin
            if (poke > 0 && cyc == poke) begin
                start    = 1'b1;
                funct3   = 3'($urandom);
                operandA = $urandom;
                operandB = $urandom;
                rdIn     = 5'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy && !ill) busy_lost = 1'b1;
        end
        check_eq({tag, ":latency"}, 64'(cyc), 64'(lat));
        check_eq({tag, ":busy_held"}, 64'(busy_lost), 64'd0);
        if (seen) begin
            check_eq({tag, ":result"}, 64'(result), 64'(exp_res));
            check_eq({tag, ":regWrite"}, 64'(regWrite), 64'(!ill && rd != 0));
            check_eq({tag, ":illegalOp"}, 64'(illegalOp), 64'(ill));
            check_eq({tag, ":busy_at_done"}, 64'(busy), 64'd0);
            if (!ill) check_eq({tag, ":rdOut"}, 64'(rdOut), 64'(rd));
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] held;
        issue(f, a, b, rd);
        finish_op(tag, f, a, b, rd, 0);
        held = result;
        @(posedge clk);
        #1;
        check_eq({tag, ":done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, ":result_hold"}, 64'(result), 64'(held));
    endtask

    initial begin
        bit          done_seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        rst      = 1'b1;
        start    = 1'b0;
        funct3   = 3'd0;
        operandA = 32'd0;
        operandB = 32'd0;
        rdIn     = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset:busy", 64'(busy), 64'd0);
        check_eq("reset:done", 64'(done), 64'd0);
        check_eq("reset:result", 64'(result), 64'd0);
        check_eq("reset:rdOut", 64'(rdOut), 64'd0);
        check_eq("reset:regWrite", 64'(regWrite), 64'd0);
        check_eq("reset:illegalOp", 64'(illegalOp), 64'd0);
        rst = 1'b0;

        run_op("mul_neg",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5);
        run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
        run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3);
        run_op("div_neg",      3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4);
        run_op("rem_neg",      3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6);
        run_op("divu_zero",    3'd5, 32'd7,          32'd0,         5'd7);
        run_op("remu_zero",    3'd7, 32'd7,          32'd0,         5'd8);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10);
        run_op("divu_9_3",     3'd5, 32'd9,          32'd3,         5'd11);
        run_op("mul_rd0",      3'd0, 32'd3,          32'd4,         5'd0);

        // Mid-op start is ignored, then a restart on the done cycle runs back to back.
        issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd12);
        finish_op("ignore_start", 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd12, 10);
        issue(3'd3, 32'hDEAD_BEEF, 32'h0000_1003, 5'd13);
        finish_op("back_to_back", 3'd3, 32'hDEAD_BEEF, 32'h0000_1003, 5'd13, 0);
        @(posedge clk);
        #1;

        // Reset during an operation aborts it silently.
        issue(DIV_EN ? 3'd4 : 3'd3, 32'hFFFF_FFF9, 32'd2, 5'd14);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort:busy", 64'(busy), 64'd0);
        check_eq("abort:done", 64'(done), 64'd0);
        check_eq("abort:result", 64'(result), 64'd0);
        check_eq("abort:rdOut", 64'(rdOut), 64'd0);
        check_eq("abort:regWrite", 64'(regWrite), 64'd0);
        check_eq("abort:illegalOp", 64'(illegalOp), 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_eq("abort:no_done", 64'(done_seen), 64'd0);

        // Reset and start on the same edge: the request is dropped.
        funct3   = 3'd0;
        operandA = 32'd5;
        operandB = 32'd6;
        rdIn     = 5'd1;
        start    = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        check_eq("rst_start:busy", 64'(busy), 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check_eq("rst_start:no_done", 64'(done_seen), 64'd0);

        for (int n = 0; n < 120; n++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d_f%0d", n, f), f, a, b, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit on the register-file read side of the SimpleCPU datapath. Consumes the two register operands read for an M-extension instruction and the destination index, computes over a fixed number of cycles, and returns the 32-bit result with a one-cycle write-back strobe that drives the register file's `writeData`/`rd`/`regWrite` inputs. The pipeline control stalls on `busy`.

## Interface
- `XLEN`, 32: operand/result width; 32 is the only supported value.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled only while `busy`=0.
- `funct3` input 3: op select; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operandA` input 32: rs1 value (dividend / multiplicand).
- `operandB` input 32: rs2 value (divisor / multiplier).
- `rdIn` input 5: destination register index.
- `busy` output 1: operation in flight; new `start` ignored.
- `done` output 1: one-cycle pulse, `result`/`rdOut` valid.
- `result` output 32: operation result; holds until next `done`.
- `rdOut` output 5: captured `rdIn`; holds until next `done`.
- `regWrite` output 1: `done` && `rdOut`!=0.
- `illegalOp` output 1: one-cycle pulse for an op compiled out (see Configuration); else 0.

## Operation
- States: IDLE, CALC, DONE. Reset -> IDLE.
- IDLE/DONE with `start`=1: latch `funct3`, operands, `rdIn`; go to CALC; iteration counter = 0.
- CALC: one radix-2 step per cycle (shift-add multiply on 64-bit product; restoring divide on magnitudes), 32 steps, plus sign fix-up; exit to DONE exactly when the fixed latency below elapses.
- DONE: `done`=1 for one cycle, then IDLE unless `start` is accepted in that same cycle (back-to-back allowed).
- Signedness: MUL low 32 bits (sign-agnostic); MULH s×s, MULHSU rs1 signed × rs2 unsigned, MULHU u×u, upper 32 bits.
- DIV/REM signed, quotient truncates toward zero, remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> operandA.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Special cases still take the full fixed latency.
- `start` while `busy`=1: ignored, no state change, latched operands unaffected.

## Timing
- Reset values: `busy`=0, `done`=0, `regWrite`=0, `illegalOp`=0, `result`=0, `rdOut`=0.
- `start` sampled at edge N -> `busy`=1 after N through the edge before N+33; `done`=1, `busy`=0 for the cycle after edge N+33.
- Fixed latency 33 cycles for every implemented op and operand value.
- `rst` mid-operation: at the next edge, abort, IDLE, all outputs to reset values; no `done` for the aborted op.
- `rst` and `start` on the same edge: `rst` wins, request dropped.
- Inputs need only be valid on the accepting edge.

## Configuration
- `MULDIV_DIV_EN` defined: all eight ops implemented as above.
- Not defined: divider datapath omitted. An accepted `start` with `funct3[2]`=1 yields `done`=1, `illegalOp`=1, `regWrite`=0, `result`=0 after edge N+1 (latency 1). Multiply ops are unchanged.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5 -> `result`=0xFFFFFFEB, `rdOut`=5, `regWrite`=1, `done` after exactly 33 cycles; MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0; all at 33 cycles.
- `start` pulsed at cycle 10 of an op with different operands -> ignored; the first op's result is unchanged; restart accepted on the `done` cycle gives a back-to-back `done` 33 cycles later.
- rd=0 MUL 3×4 -> `done`=1, `result`=12, `regWrite`=0.
- `rst` at cycle 20 of a DIV -> next cycle all outputs 0, no `done` within 40 cycles.
- Without `MULDIV_DIV_EN`: DIVU 9/3 -> after 1 cycle `done`=1, `illegalOp`=1, `result`=0, `regWrite`=0; MUL still 33 cycles.
